// File: rtl/sqrt_share_arbiter_if.sv
// Handshake bundle between the sqrt arbiter (master side), its two requesters
// and the shared square-root unit (slave side).
interface sqrt_share_arbiter_if #(
    parameter int W = 5
);
    logic         r0_req;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;
    logic         r0_gnt;
    logic         r0_valid;
    logic [W-1:0] r0_result;
    logic         r0_err;

    logic         r1_req;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;
    logic         r1_gnt;
    logic         r1_valid;
    logic [W-1:0] r1_result;
    logic         r1_err;

    logic         sq_start;
    logic [W-1:0] sq_in1;
    logic [W-1:0] sq_in2;
    logic [W-1:0] sq_O;
    logic         sq_done;

    modport master (
        input  r0_req, r0_a, r0_b, r1_req, r1_a, r1_b, sq_O, sq_done,
        output r0_gnt, r0_valid, r0_result, r0_err,
        output r1_gnt, r1_valid, r1_result, r1_err,
        output sq_start, sq_in1, sq_in2
    );

    modport slave (
        output r0_req, r0_a, r0_b, r1_req, r1_a, r1_b, sq_O, sq_done,
        input  r0_gnt, r0_valid, r0_result, r0_err,
        input  r1_gnt, r1_valid, r1_result, r1_err,
        input  sq_start, sq_in1, sq_in2
    );
endinterface

// File: rtl/sqrt_share_arbiter.sv
// Round-robin arbiter sharing one square-root unit between two requesters.
// Define SQRT_ARB_TIMEOUT_EN to add a WAIT-state watchdog (TIMEOUT_CYCLES).
module sqrt_share_arbiter #(
    parameter int W              = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    sqrt_share_arbiter_if.master bus,
    output logic                busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_owner;
    logic         r_rr_ptr;
    logic         r_busy;
    logic         r_start;
    logic [W-1:0] r_op1;
    logic [W-1:0] r_op2;
    logic [1:0]   r_gnt;
    logic [1:0]   r_valid;
    logic [1:0]   r_err;
    logic [W-1:0] r_result [2];

    logic [1:0]   w_req;
    logic [W-1:0] w_a [2];
    logic [W-1:0] w_b [2];
    logic         w_win;
    logic         w_timeout;

    assign w_req  = {bus.r1_req, bus.r0_req};
    assign w_a[0] = bus.r0_a;
    assign w_a[1] = bus.r1_a;
    assign w_b[0] = bus.r0_b;
    assign w_b[1] = bus.r1_b;

    // A lone requester always wins; on contention rr_ptr picks.
    assign w_win = (w_req == 2'b11) ? r_rr_ptr : w_req[1];

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Fires on the last allowed WAIT cycle; a coincident done takes precedence.
    assign w_timeout = (r_state == S_WAIT) && !bus.sq_done &&
                       (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_gnt       <= '0;
            r_valid     <= '0;
            r_err       <= '0;
            r_result[0] <= '0;
            r_result[1] <= '0;
        end else begin
            r_gnt   <= '0;
            r_valid <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_owner      <= w_win;
                        r_op1        <= w_a[w_win];
                        r_op2        <= w_b[w_win];
                        r_start      <= 1'b1;
                        r_gnt[w_win] <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.sq_done || w_timeout) begin
                        r_result[r_owner] <= bus.sq_done ? bus.sq_O : {W{1'b1}};
                        r_err[r_owner]    <= w_timeout;
                        r_valid[r_owner]  <= 1'b1;
                        r_state           <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= ~r_owner;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.r0_gnt    = r_gnt[0];
    assign bus.r1_gnt    = r_gnt[1];
    assign bus.r0_valid  = r_valid[0];
    assign bus.r1_valid  = r_valid[1];
    assign bus.r0_result = r_result[0];
    assign bus.r1_result = r_result[1];
    assign bus.r0_err    = r_err[0];
    assign bus.r1_err    = r_err[1];
    assign bus.sq_start  = r_start;
    assign bus.sq_in1    = r_op1;
    assign bus.sq_in2    = r_op2;
    assign busy          = r_busy;
endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Randomised scoreboard bench for sqrt_share_arbiter; the unit model returns
// in1+in2 five cycles after sq_start.
`timescale 1ns/1ps
module tb_sqrt_share_arbiter;
    localparam int W  = 5;
    localparam int TO = 8;
`ifdef SQRT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    sqrt_share_arbiter_if #(.W(W)) bus ();
    sqrt_share_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    logic [1:0]   req = 2'b00;
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic         u_done = 1'b0;
    logic [W-1:0] u_o = '0;

    assign bus.r0_req  = req[0];
    assign bus.r1_req  = req[1];
    assign bus.r0_a    = op_a[0];
    assign bus.r0_b    = op_b[0];
    assign bus.r1_a    = op_a[1];
    assign bus.r1_b    = op_b[1];
    assign bus.sq_done = u_done;
    assign bus.sq_O    = u_o;

    int n_cmp = 0;
    int n_bad = 0;
    int q0[$];
    int q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Expected code: bit W = err, bits W-1:0 = result.
    function automatic int exp_of(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'(a) + int'(b)) % (1 << W);
    endfunction

    function automatic logic [27:0] outs();
        return {bus.r0_gnt, bus.r1_gnt, bus.r0_valid, bus.r1_valid,
                bus.r0_result, bus.r1_result, bus.r0_err, bus.r1_err,
                bus.sq_start, bus.sq_in1, bus.sq_in2, busy};
    endfunction

    // Square-root unit stand-in: done (held done_hold cycles) 5 cycles after start.
    int done_hold = 1;
    int cd = 0;
    int hold_left = 0;
    logic [W-1:0] pend_o = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    hold_left = done_hold;
                    u_o = pend_o;
                end
            end
            u_done = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            if (bus.sq_start === 1'b1) begin
                cd = 5;
                pend_o = bus.sq_in1 + bus.sq_in2;
            end
        end
    end

    // Monitor / scoreboard
    logic [1:0]   prev_req = 2'b00;
    logic         prev_busy = 1'b0;
    logic         prev_rst = 1'b1;
    logic         in_wait = 1'b0;
    logic         exp_v = 1'b0;
    logic         owner = 1'b0;
    logic         last_owner = 1'b1;
    int           wait_cnt = 0;
    logic [W-1:0] cap1 = '0;
    logic [W-1:0] cap2 = '0;
    logic [W-1:0] last_res [2] = '{default: '0};

    always @(negedge clk) begin : mon
        logic [1:0]   g;
        logic [1:0]   v;
        logic         exp_gnt;
        logic         exp_v_next;
        logic [W-1:0] res;
        logic         err;
        int           e;
        g = {bus.r1_gnt, bus.r0_gnt};
        v = {bus.r1_valid, bus.r0_valid};
        if (rst) begin
            in_wait     = 1'b0;
            exp_v       = 1'b0;
            last_owner  = 1'b1;
            last_res[0] = '0;
            last_res[1] = '0;
        end else begin
            exp_gnt = !prev_busy && !prev_rst && (prev_req != 2'b00);
            check("gnt_issued", {31'b0, |g}, {31'b0, exp_gnt});
            check("sq_start", {31'b0, bus.sq_start}, {31'b0, exp_gnt});
            if (|g) begin
                check("gnt_onehot", {30'b0, g}, (g[1] ? 32'd2 : 32'd1));
                owner = g[1];
                if (prev_req == 2'b11) check("rr_winner", {31'b0, owner}, {31'b0, ~last_owner});
                else check("gnt_to_requester", {31'b0, prev_req[owner]}, 32'd1);
                check("sq_in1", {27'b0, bus.sq_in1}, {27'b0, op_a[owner]});
                check("sq_in2", {27'b0, bus.sq_in2}, {27'b0, op_b[owner]});
                cap1 = bus.sq_in1;
                cap2 = bus.sq_in2;
            end
            check("busy", {31'b0, busy}, {31'b0, (|g) || in_wait || exp_v});
            if (in_wait || exp_v) begin
                check("sq_in1_hold", {27'b0, bus.sq_in1}, {27'b0, cap1});
                check("sq_in2_hold", {27'b0, bus.sq_in2}, {27'b0, cap2});
            end
            check("valid_issued", {31'b0, |v}, {31'b0, exp_v});
            if (exp_v && (|v)) begin
                check("valid_owner", {30'b0, v}, (owner ? 32'd2 : 32'd1));
                res = owner ? bus.r1_result : bus.r0_result;
                err = owner ? bus.r1_err : bus.r0_err;
                if ((owner ? q1.size() : q0.size()) == 0) begin
                    fail_now("valid_without_request");
                end else begin
                    e = owner ? q1.pop_front() : q0.pop_front();
                    check(owner ? "r1_result" : "r0_result", {27'b0, res}, e & ((1 << W) - 1));
                    check(owner ? "r1_err" : "r0_err", {31'b0, err}, (e >> W) & 1);
                end
                last_res[owner] = res;
                last_owner = owner;
            end
            if (!v[0]) check("r0_result_hold", {27'b0, bus.r0_result}, {27'b0, last_res[0]});
            if (!v[1]) check("r1_result_hold", {27'b0, bus.r1_result}, {27'b0, last_res[1]});
            exp_v_next = 1'b0;
            if (in_wait) begin
                wait_cnt++;
                if (bus.sq_done === 1'b1) begin
                    exp_v_next = 1'b1;
                    in_wait = 1'b0;
                end else if (TO_EN && wait_cnt == TO) begin
                    exp_v_next = 1'b1;
                    in_wait = 1'b0;
                end
            end
            if (|g) begin
                in_wait = 1'b1;
                wait_cnt = 0;
            end
            exp_v = exp_v_next;
        end
        prev_req  = {bus.r1_req, bus.r0_req};
        prev_busy = busy;
        prev_rst  = rst;
    end

    // One request: post operands, record the expectation, wait for the grant.
    task automatic req_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp, input bit keep);
        int k;
        op_a[i] = a;
        op_b[i] = b;
        req[i]  = 1'b1;
        if (exp >= 0) begin
            if (i == 0) q0.push_back(exp);
            else q1.push_back(exp);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(i == 1 ? bus.r1_gnt : bus.r0_gnt) && k < 300);
        if (k >= 300) fail_now("gnt_wait_expired");
        $display("req r%0d a=%0d b=%0d granted after %0d cycles", i, a, b, k);
        @(posedge clk);
        #1;
        if (!keep) req[i] = 1'b0;
    endtask

    task automatic drive(input int i, input int n, input bit hold_all);
        for (int t = 0; t < n; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit keep;
            a = W'($urandom);
            b = W'($urandom);
            keep = (t < n - 1) && (hold_all || ($urandom_range(0, 1) == 1));
            req_one(i, a, b, exp_of(a, b), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || q0.size() != 0 || q1.size() != 0) && k < 1000);
        if (k >= 1000) fail_now("drain_expired");
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {4'b0, outs()}, 32'd0);
    endtask

    initial begin : main
        int cnt;
        op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {4'b0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both request at reset exit: r0 first, then r1.
        fork
            req_one(0, 5'd2, 5'd2, 4, 1'b0);
            req_one(1, 5'd5, 5'd1, 6, 1'b0);
        join
        wait_idle();

        // Lone requester r0 with 3+4.
        req_one(0, 5'd3, 5'd4, 7, 1'b0);
        wait_idle();

        // Both hold req continuously: grants must alternate.
        fork
            drive(0, 4, 1'b1);
            drive(1, 4, 1'b1);
        join
        wait_idle();

        // Randomised mix with varying done lengths.
        for (int r = 0; r < 4; r++) begin
            done_hold = $urandom_range(1, 3);
            fork
                drive(0, 3, 1'b0);
                drive(1, 3, 1'b0);
            join
            wait_idle();
        end

        // done held 3 cycles: one valid only.
        done_hold = 3;
        req_one(1, 5'd9, 5'd10, 19, 1'b0);
        wait_idle();
        done_hold = 1;

        // Reset two cycles into WAIT; the late done must be ignored.
        req_one(0, 5'd1, 5'd1, -1, 1'b0);
        pulse_reset();
        repeat (8) @(negedge clk);
        req_one(1, 5'd12, 5'd13, 25, 1'b0);
        wait_idle();

        // Unit never answers.
        done_hold = 0;
`ifdef SQRT_ARB_TIMEOUT_EN
        req_one(1, 5'd6, 5'd6, (1 << W) | 31, 1'b0);
        wait_idle();
`else
        req_one(1, 5'd6, 5'd6, -1, 1'b0);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("busy_without_done", cnt, 200);
        pulse_reset();
`endif
        done_hold = 1;
        repeat (8) @(negedge clk);
        req_one(0, 5'd15, 5'd16, 31, 1'b0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        fail_now("global_time_limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Round-robin arbiter that time-shares one 5-bit square-root approximation unit between two requesters.
- Accepts operand pairs over a req/gnt handshake and drives the unit's start/in1/in2 inputs.
- Waits for the unit's done, then returns the unit's O result to the winning requester with a one-cycle valid.
- Sits between the requesting logic and the squareroot unit; it is the unit's only driver.

Parameters:
- W, 5, operand/result width; must match the square-root unit.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit in cycles; used only with SQRT_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- r0_req  in  1  requester 0 request; held high until r0_gnt
- r0_a  in  W  requester 0 operand 1
- r0_b  in  W  requester 0 operand 2
- r0_gnt  out  1  one-cycle pulse: r0 operands captured
- r0_valid  out  1  one-cycle pulse: r0_result valid
- r0_result  out  W  result for r0
- r0_err  out  1  with r0_valid: result is a timeout substitute
- r1_req, r1_a, r1_b, r1_gnt, r1_valid, r1_result, r1_err: same as r0, for requester 1
- sq_start  out  1  start to the square-root unit
- sq_in1  out  W  operand 1 to the unit
- sq_in2  out  W  operand 2 to the unit
- sq_O  in  W  unit result
- sq_done  in  1  unit done (may be level or pulse)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs are 0. State = IDLE; owner = 0; rr_ptr = 0 (r0 has priority first); operand and result registers cleared.
- Reset asserted in any state aborts the operation: no valid is issued and the unit's late done is ignored.
- FSM, IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester selected by rr_ptr.
  - On grant: latch a/b into the operand registers, latch owner, move to ISSUE.
  - No req: stay in IDLE.
- ISSUE, exactly 1 cycle:
  - sq_start = 1; the owner's gnt = 1.
  - Move to WAIT.
- WAIT:
  - sq_start = 0.
  - On the first cycle sq_done = 1: capture sq_O into the result register and move to RESP.
  - sq_done seen in any other state is ignored.
- RESP, exactly 1 cycle:
  - The owner's valid = 1 and its result = captured value; the other requester's valid stays 0.
  - rr_ptr = ~owner.
  - Move to IDLE.
- sq_in1/sq_in2 are driven from the operand registers and held stable from ISSUE through RESP.
- Results and err are registered and hold their last value between valids.
- Latency:
  - req sampled at edge k in IDLE -> gnt and sq_start high in cycle k+1.
  - sq_done high in cycle d -> valid high in cycle d+1 -> back in IDLE at d+2.
- A requester holding req through its own valid is re-arbitrated in IDLE; rr_ptr lets the other requester win if it is also requesting.
- Requests arriving during ISSUE/WAIT/RESP are not acknowledged until IDLE. req must stay high; operands are sampled only at grant.
- There is no back-pressure on valid; the requester must accept it.

Optional Feature:
- SQRT_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no sq_done, move to RESP with result = all ones and the owner's err = 1 alongside valid.
  - A sq_done arriving in the same cycle as the limit wins: normal result, err = 0.
- Not defined:
  - No counter; WAIT waits indefinitely.
  - r0_err and r1_err are tied to 0.

Test Plan:
- Bench uses a unit model returning in1+in2 five cycles after sq_start.
- r0 only, a=3, b=4: r0_gnt at k+1; sq_in1=3, sq_in2=4; r0_valid with r0_result=7 at d+1; r1_valid stays 0; busy high from k+1 to d+1.
- r0 and r1 both request at reset exit (r0: 2,2; r1: 5,1): r0 is served first (result 4), then r1 (result 6); gnt pulses never overlap.
- Both requesters hold req continuously for 4 transactions: grants alternate r0, r1, r0, r1.
- rst asserted 2 cycles into WAIT, with the model's done arriving 3 cycles later: all outputs 0, no valid, state IDLE, next request served normally.
- With SQRT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, model never asserts done: r1_valid=1, r1_err=1, r1_result=5'h1F at the 8th WAIT cycle + 1; without the macro, busy stays high for 200 cycles.
- Model holds done high for 3 cycles: exactly one valid is issued; the held done does not trigger a second valid.
